// File: rtl/ram_exp_pkg.sv
// Shared types and constants for the CPC expansion-RAM bus cycle sequencer.
//   cyc_type_e : externally visible bus cycle class encoding
//   state_e    : sequencer FSM states
//   BANK_CMD   : data[7:6] value of a bank-select OUT
//   MODE3_CODE : ramblock[2:0] value that selects mapping mode 3
package ram_exp_pkg;

    typedef enum logic [2:0] {
        CycIdle  = 3'd0,
        CycFetch = 3'd1,
        CycMrd   = 3'd2,
        CycMwr   = 3'd3,
        CycRfsh  = 3'd4,
        CycIowr  = 3'd5,
        CycIord  = 3'd6,
        CycInta  = 3'd7
    } cyc_type_e;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StMrd,
        StMwr,
        StRfsh,
        StIowr,
        StIord,
        StInta,
        StHold
    } state_e;

    localparam logic [1:0] BANK_CMD   = 2'b11;
    localparam logic [2:0] MODE3_CODE = 3'b011;

    // HOLD has no class of its own and reports as IDLE.
    function automatic cyc_type_e state_to_cyc(state_e st);
        cyc_type_e c;
        unique case (st)
            StFetch: c = CycFetch;
            StMrd:   c = CycMrd;
            StMwr:   c = CycMwr;
            StRfsh:  c = CycRfsh;
            StIowr:  c = CycIowr;
            StIord:  c = CycIord;
            StInta:  c = CycInta;
            default: c = CycIdle;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ram_wait_counter.sv
// Wait-state counter for expansion-RAM reads and fetches.
//   clk_i, rst_ni : bus clock, asynchronous active-low reset
//   load_i        : load LOAD_VAL (wins over clear)
//   clear_i       : drop the count to zero (cycle ended early)
//   ready_pull_o  : high while the count is non-zero
module ram_wait_counter #(
    parameter int unsigned LOAD_VAL = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic clear_i,
    output logic ready_pull_o
);

    // Two-bit counter: anything above 3 saturates.
    localparam logic [1:0] LoadVal = (LOAD_VAL > 3) ? 2'd3 : LOAD_VAL[1:0];

    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (clear_i) begin
            cnt_d = 2'd0;
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ready_pull_o = (cnt_q != 2'd0);

endmodule

// File: rtl/ram_bus_cycle_sequencer.sv
// Follows each Z80 bus cycle on the CPC expansion port and classifies it. Supplies the RAM
// mapping logic with the bank-select register, mode-3 flag, latched A15 and write qualifier,
// and requests READY low for expansion-RAM wait states.
//   inputs  : Z80 strobes (mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b), adr15/adr14, data,
//             shadow_en/shadow_bank (DIP latch), exp_sel (mapping decode)
//   outputs : cyc_type, mwr_cyc, ramblock, mode3, adr15_lat, bank_wr, ready_pull
module ram_bus_cycle_sequencer #(
    parameter int unsigned EXP_WAIT     = 0,
    parameter bit          SHADOW_ALIAS = 1'b1
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       mreq_b,
    input  logic       iorq_b,
    input  logic       rd_b,
    input  logic       wr_b,
    input  logic       m1_b,
    input  logic       rfsh_b,
    input  logic       adr15,
    input  logic       adr14,
    input  logic [7:0] data,
    input  logic       shadow_en,
    input  logic [2:0] shadow_bank,
    input  logic       exp_sel,
    output logic [2:0] cyc_type,
    output logic       mwr_cyc,
    output logic [5:0] ramblock,
    output logic       mode3,
    output logic       adr15_lat,
    output logic       bank_wr,
    output logic       ready_pull
);

    import ram_exp_pkg::*;

    // A14 takes part only in the downstream address decode.
    logic unused_adr14;
    assign unused_adr14 = adr14;

    state_e    state_q, state_d;
    cyc_type_e cyc_type_q, cyc_type_d;
    logic      armed_q, armed_d;     // an idle bus edge has been seen since reset
    logic      loaded_q, loaded_d;   // bank already loaded in this IO cycle
    logic      adr15_lat_q, adr15_lat_d;
    logic      mwr_cyc_q, mwr_cyc_d;
    logic [5:0] ramblock_q, ramblock_d;
    logic      mode3_q, mode3_d;
    logic      bank_wr_q, bank_wr_d;
    logic      bus_idle, new_class, wait_load;

    assign bus_idle = mreq_b & iorq_b;

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | bus_idle;
        loaded_d    = loaded_q;
        adr15_lat_d = adr15_lat_q;
        mwr_cyc_d   = mwr_cyc_q;
        ramblock_d  = ramblock_q;
        mode3_d     = mode3_q;
        bank_wr_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                loaded_d = 1'b0;
                // After reset, wait for a clean idle edge so a cycle in flight is ignored.
                if (armed_q) begin
                    if (!mreq_b) begin
                        if (!rfsh_b)    state_d = StRfsh;
                        else if (!m1_b) state_d = StFetch;
                        else if (!rd_b) state_d = StMrd;
                        else            state_d = StMwr;
                    end else if (!iorq_b) begin
                        if (!m1_b)      state_d = StInta;
                        else if (!wr_b) state_d = StIowr;
                        else if (!rd_b) state_d = StIord;
                    end
                end
            end
            StIowr: begin
                if (bus_idle) state_d = StHold;
                if (!loaded_q && !wr_b && !adr15 && (data[7:6] == BANK_CMD)) begin
                    loaded_d  = 1'b1;
                    bank_wr_d = 1'b1;
                    mode3_d   = (data[2:0] == MODE3_CODE);
                    if (SHADOW_ALIAS && shadow_en && (data[5:3] == shadow_bank)) begin
                        ramblock_d = {data[5:4], 1'b0, data[2:0]};
                    end else begin
                        ramblock_d = data[5:0];
                    end
                end
            end
            StFetch, StMrd, StMwr, StRfsh, StIord, StInta: begin
                if (bus_idle) state_d = StHold;
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        new_class = (state_q == StIdle) && (state_d != StIdle);
        if (new_class) adr15_lat_d = adr15;

        if (new_class && (state_d == StMwr)) begin
            mwr_cyc_d = 1'b1;
        end else if (mreq_b) begin
            mwr_cyc_d = 1'b0;
        end

        wait_load  = new_class && exp_sel && ((state_d == StFetch) || (state_d == StMrd));
        cyc_type_d = state_to_cyc(state_d);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= StIdle;
            cyc_type_q  <= CycIdle;
            armed_q     <= 1'b0;
            loaded_q    <= 1'b0;
            adr15_lat_q <= 1'b0;
            mwr_cyc_q   <= 1'b0;
            ramblock_q  <= 6'd0;
            mode3_q     <= 1'b0;
            bank_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_type_q  <= cyc_type_d;
            armed_q     <= armed_d;
            loaded_q    <= loaded_d;
            adr15_lat_q <= adr15_lat_d;
            mwr_cyc_q   <= mwr_cyc_d;
            ramblock_q  <= ramblock_d;
            mode3_q     <= mode3_d;
            bank_wr_q   <= bank_wr_d;
        end
    end

    ram_wait_counter #(
        .LOAD_VAL(EXP_WAIT)
    ) u_wait_counter (
        .clk_i       (clk),
        .rst_ni      (reset_b),
        .load_i      (wait_load),
        .clear_i     (mreq_b),
        .ready_pull_o(ready_pull)
    );

    assign cyc_type  = cyc_type_q;
    assign mwr_cyc   = mwr_cyc_q;
    assign ramblock  = ramblock_q;
    assign mode3     = mode3_q;
    assign adr15_lat = adr15_lat_q;
    assign bank_wr   = bank_wr_q;

endmodule

// File: tb/tb_ram_bus_cycle_sequencer.sv
`timescale 1ns / 1ps
module tb_ram_bus_cycle_sequencer;

    localparam logic [2:0] C_FETCH = 3'd1;
    localparam logic [2:0] C_MRD   = 3'd2;
    localparam logic [2:0] C_MWR   = 3'd3;
    localparam logic [2:0] C_RFSH  = 3'd4;
    localparam logic [2:0] C_IOWR  = 3'd5;
    localparam logic [2:0] C_IORD  = 3'd6;
    localparam logic [2:0] C_INTA  = 3'd7;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       mreq_b = 1'b1, iorq_b = 1'b1, rd_b = 1'b1, wr_b = 1'b1;
    logic       m1_b = 1'b1, rfsh_b = 1'b1, adr15 = 1'b0, adr14 = 1'b0;
    logic [7:0] data = 8'h00;
    logic       shadow_en = 1'b0;
    logic [2:0] shadow_bank = 3'd0;
    logic       exp_sel = 1'b0;
    logic [2:0] cyc_type;
    logic       mwr_cyc, mode3, adr15_lat, bank_wr, ready_pull;
    logic [5:0] ramblock;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: expected pushed by stimulus, observed pushed by the monitor.
    logic [3:0] exp_cls_q[$], obs_cls_q[$];   // {adr15_lat, cyc_type}
    logic [6:0] exp_bank_q[$], obs_bank_q[$]; // {mode3, ramblock}
    int ready_cnt = 0, mwr_cnt = 0, bank_wr_cnt = 0;
    logic [2:0] prev_cyc = 3'd0;
    int r0, m0, b0;

    ram_bus_cycle_sequencer #(
        .EXP_WAIT    (2),
        .SHADOW_ALIAS(1'b1)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .mreq_b     (mreq_b),
        .iorq_b     (iorq_b),
        .rd_b       (rd_b),
        .wr_b       (wr_b),
        .m1_b       (m1_b),
        .rfsh_b     (rfsh_b),
        .adr15      (adr15),
        .adr14      (adr14),
        .data       (data),
        .shadow_en  (shadow_en),
        .shadow_bank(shadow_bank),
        .exp_sel    (exp_sel),
        .cyc_type   (cyc_type),
        .mwr_cyc    (mwr_cyc),
        .ramblock   (ramblock),
        .mode3      (mode3),
        .adr15_lat  (adr15_lat),
        .bank_wr    (bank_wr),
        .ready_pull (ready_pull)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bank_wr) obs_bank_q.push_back({mode3, ramblock});
        if (cyc_type != prev_cyc && cyc_type != 3'd0) obs_cls_q.push_back({adr15_lat, cyc_type});
        prev_cyc = cyc_type;
        if (ready_pull) ready_cnt++;
        if (mwr_cyc) mwr_cnt++;
        if (bank_wr) bank_wr_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_scoreboard(input string tag);
        chk({tag, " class_count"}, obs_cls_q.size(), exp_cls_q.size());
        while (obs_cls_q.size() > 0 && exp_cls_q.size() > 0)
            chk({tag, " class"}, {28'd0, obs_cls_q.pop_front()}, {28'd0, exp_cls_q.pop_front()});
        chk({tag, " bank_count"}, obs_bank_q.size(), exp_bank_q.size());
        while (obs_bank_q.size() > 0 && exp_bank_q.size() > 0)
            chk({tag, " bank"}, {25'd0, obs_bank_q.pop_front()}, {25'd0, exp_bank_q.pop_front()});
        obs_cls_q.delete();
        exp_cls_q.delete();
        obs_bank_q.delete();
        exp_bank_q.delete();
    endtask

    task automatic bus_release();
        mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1; rfsh_b = 1'b1;
    endtask

    // Drive one bus cycle for 'hold' edges, then leave the bus idle for three edges.
    task automatic cycle(input logic mq, input logic iq, input logic rd, input logic wr,
                         input logic m1, input logic rf, input logic a15,
                         input logic [7:0] d, input int hold);
        @(posedge clk); #1;
        mreq_b = mq; iorq_b = iq; rd_b = rd; wr_b = wr; m1_b = m1; rfsh_b = rf;
        adr15 = a15; data = d;
        repeat (hold) @(posedge clk);
        #1 bus_release();
        repeat (3) @(posedge clk);
    endtask

    task automatic snap();
        r0 = ready_cnt; m0 = mwr_cnt; b0 = bank_wr_cnt;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset cyc_type", {29'd0, cyc_type}, 32'd0);
        chk("reset ramblock", {26'd0, ramblock}, 32'd0);
        chk("reset outputs", {27'd0, mode3, mwr_cyc, bank_wr, ready_pull, adr15_lat}, 32'd0);
        reset_b = 1'b1;
        repeat (3) @(posedge clk);

        // OUT &7F00,&C5: bank load
        snap();
        exp_cls_q.push_back({1'b0, C_IOWR});
        exp_bank_q.push_back(7'b0_000101);
        cycle(1, 0, 1, 0, 1, 1, 0, 8'hC5, 3);
        check_scoreboard("out_c5");
        chk("out_c5 pulses", bank_wr_cnt - b0, 1);

        // OUT &7F00,&8C: not a bank command
        snap();
        exp_cls_q.push_back({1'b0, C_IOWR});
        cycle(1, 0, 1, 0, 1, 1, 0, 8'h8C, 3);
        check_scoreboard("out_8c");
        chk("out_8c ramblock", {26'd0, ramblock}, 32'b000101);
        chk("out_8c pulses", bank_wr_cnt - b0, 0);

        // OUT with A15=1: not addressed to the bank register
        exp_cls_q.push_back({1'b1, C_IOWR});
        cycle(1, 0, 1, 0, 1, 1, 1, 8'hD7, 3);
        check_scoreboard("out_a15");
        chk("out_a15 ramblock", {26'd0, ramblock}, 32'b000101);

        // Shadow alias: OUT &7F00,&DB with shadow bank 3
        shadow_en = 1'b1; shadow_bank = 3'b011;
        exp_cls_q.push_back({1'b0, C_IOWR});
        exp_bank_q.push_back(7'b1_010011);
        cycle(1, 0, 1, 0, 1, 1, 0, 8'hDB, 3);
        check_scoreboard("shadow");
        chk("shadow mode3", {31'd0, mode3}, 32'd1);

        // Memory write to &C000
        snap();
        exp_cls_q.push_back({1'b1, C_MWR});
        cycle(0, 1, 1, 0, 1, 1, 1, 8'h55, 4);
        check_scoreboard("mwr");
        chk("mwr high clocks", mwr_cnt - m0, 4);
        chk("mwr ready", ready_cnt - r0, 0);
        chk("mwr fell", {31'd0, mwr_cyc}, 32'd0);

        // Expansion fetch with waits
        exp_sel = 1'b1;
        snap();
        exp_cls_q.push_back({1'b0, C_FETCH});
        cycle(0, 1, 0, 1, 0, 1, 0, 8'h00, 4);
        check_scoreboard("fetch_exp");
        chk("fetch_exp ready clocks", ready_cnt - r0, 2);

        // Refresh with exp_sel still high: no waits
        snap();
        exp_cls_q.push_back({1'b0, C_RFSH});
        cycle(0, 1, 1, 1, 1, 0, 0, 8'h00, 2);
        check_scoreboard("rfsh");
        chk("rfsh ready", ready_cnt - r0, 0);

        // Expansion read cut short: counter clears when mreq_b rises
        snap();
        exp_cls_q.push_back({1'b1, C_MRD});
        cycle(0, 1, 0, 1, 1, 1, 1, 8'h00, 1);
        check_scoreboard("mrd_short");
        chk("mrd_short ready clocks", ready_cnt - r0, 1);

        // Fetch without expansion RAM selected
        exp_sel = 1'b0;
        snap();
        exp_cls_q.push_back({1'b0, C_FETCH});
        cycle(0, 1, 0, 1, 0, 1, 0, 8'h00, 4);
        check_scoreboard("fetch_int");
        chk("fetch_int ready", ready_cnt - r0, 0);

        // Interrupt acknowledge with &FF on the bus
        snap();
        exp_cls_q.push_back({1'b0, C_INTA});
        cycle(1, 0, 1, 1, 0, 1, 0, 8'hFF, 3);
        check_scoreboard("inta");
        chk("inta pulses", bank_wr_cnt - b0, 0);

        // IO read
        exp_cls_q.push_back({1'b1, C_IORD});
        cycle(1, 0, 0, 1, 1, 1, 1, 8'hC0, 3);
        check_scoreboard("iord");

        // Reset during an IO write before WR falls
        snap();
        @(posedge clk); #1;
        iorq_b = 1'b0; adr15 = 1'b0; data = 8'hC5;
        @(posedge clk); #2;
        reset_b = 1'b0;
        #1;
        chk("midreset ramblock", {26'd0, ramblock}, 32'd0);
        chk("midreset mode3", {31'd0, mode3}, 32'd0);
        @(posedge clk); #1;
        reset_b = 1'b1;
        @(posedge clk); #1;
        wr_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus_release();
        repeat (3) @(posedge clk);
        check_scoreboard("midreset");
        chk("midreset pulses", bank_wr_cnt - b0, 0);
        chk("midreset ramblock after", {26'd0, ramblock}, 32'd0);

        // Classification resumes after the idle edge
        exp_cls_q.push_back({1'b0, C_IOWR});
        exp_bank_q.push_back(7'b0_000101);
        cycle(1, 0, 1, 0, 1, 1, 0, 8'hC5, 3);
        check_scoreboard("after_reset");

        // Back-to-back fetch then read with a single idle edge in between
        exp_cls_q.push_back({1'b0, C_FETCH});
        exp_cls_q.push_back({1'b1, C_MRD});
        @(posedge clk); #1;
        mreq_b = 1'b0; m1_b = 1'b0; rd_b = 1'b0; adr15 = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus_release();
        @(posedge clk); #1;
        mreq_b = 1'b0; rd_b = 1'b0; adr15 = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_release();
        repeat (3) @(posedge clk);
        check_scoreboard("b2b");
        chk("b2b end idle", {29'd0, cyc_type}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
